// File: rtl/flipflop_pkg.sv
// Shared constants for the button/LED set-reset latch.
package flipflop_pkg;

  // Buttons are active-low at the pin and on the clean levels.
  localparam logic BTN_RELEASED = 1'b1;
  localparam logic BTN_PRESSED  = 1'b0;

  // LED levels while in reset (latch cleared).
  localparam logic LED0_RST = 1'b0;
  localparam logic LED1_RST = 1'b1;

  // 1 ms at 50 MHz.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, persistence counter and clean level with press/release pulses.
module btn_debounce
  import flipflop_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic clean,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  assign s = sync_q[1];

  // Accept a new level only after it has persisted DEBOUNCE_CYCLES cycles.
  always_comb begin
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d     = '0;
      clean_d   = s;
      press_d   = (s == BTN_PRESSED);
      release_d = (s == BTN_RELEASED);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter, clean level and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {2{BTN_RELEASED}};
      cnt_q     <= '0;
      clean_q   <= BTN_RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn};
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign clean         = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/btn_debounce_latch.sv
// Debounced red/blue buttons driving a clocked set-reset latch and two LEDs.
module btn_debounce_latch
  import flipflop_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic redbtn,
  input  logic bluebtn,
  output logic red_clean,
  output logic blue_clean,
  output logic red_press,
  output logic blue_press,
  output logic red_release,
  output logic blue_release,
  output logic led0,
  output logic led1
);

  logic red_held, blue_held;
  logic q_q, q_d;
  logic led0_q, led0_d;
  logic led1_q, led1_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_red (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (redbtn),
    .clean        (red_clean),
    .press_pulse  (red_press),
    .release_pulse(red_release)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_blue (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (bluebtn),
    .clean        (blue_clean),
    .press_pulse  (blue_press),
    .release_pulse(blue_release)
  );

  assign red_held  = (red_clean == BTN_PRESSED);
  assign blue_held = (blue_clean == BTN_PRESSED);

  // Latch next state and LED levels; both-held forces the NAND forbidden state 1/1.
  always_comb begin
    q_d = q_q;
    if (red_held && !blue_held) begin
      q_d = 1'b1;
    end else if (blue_held && !red_held) begin
      q_d = 1'b0;
    end
    if (red_held && blue_held) begin
      led0_d = 1'b1;
      led1_d = 1'b1;
    end else begin
      led0_d = q_d;
      led1_d = ~q_d;
    end
  end

  // Latch state and registered LED drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= 1'b0;
      led0_q <= LED0_RST;
      led1_q <= LED1_RST;
    end else begin
      q_q    <= q_d;
      led0_q <= led0_d;
      led1_q <= led1_d;
    end
  end

  assign led0 = led0_q;
  assign led1 = led1_q;

endmodule

// File: doc/btn_debounce_latch.md
Name: btn_debounce_latch

Overview:
Input-side conditioning for the button/LED set-reset latch. It synchronises and debounces the two active-low push-buttons (red, blue) and produces clean levels and one-cycle press/release pulses. It holds the set/reset state in a clocked register and drives the two complementary LEDs. It is the clocked replacement for the asynchronous cross-coupled NAND pair, with identical steady-state truth table, and sits directly between the board pins and the LEDs.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronised level must persist before it is accepted (1 ms at 50 MHz); legal range 2 to 2^24.
CNT_W, $clog2(DEBOUNCE_CYCLES), derived width of each debounce counter; not overridden by users.

Ports:
clk  input  1  system clock; sole clock domain.
rst_n  input  1  asynchronous, active-low reset.
redbtn  input  1  raw red button pin, asynchronous, active-low (0 = pressed).
bluebtn  input  1  raw blue button pin, asynchronous, active-low (0 = pressed).
red_clean  output  1  debounced red level, active-low.
blue_clean  output  1  debounced blue level, active-low.
red_press  output  1  one-cycle pulse on accepted red press (clean 1->0).
blue_press  output  1  one-cycle pulse on accepted blue press.
red_release  output  1  one-cycle pulse on accepted red release (clean 0->1).
blue_release  output  1  one-cycle pulse on accepted blue release.
led0  output  1  red-side LED, registered.
led1  output  1  blue-side LED, registered.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release on clk): sync flops=1, clean=1, counters=0, all pulses=0, state q=0, led0=0, led1=1. Reset mid-count discards the partial count.
- Synchroniser: 2-flop chain per button; synced level s lags the pin by 2 rising edges.
- Debounce, per button:
  - If s == clean, counter clears to 0.
  - If s != clean, counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and s != clean: clean <= s, counter <= 0, and the matching press or release pulse is asserted for exactly that cycle.
  - Any s reversal before acceptance clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: a clean pin step appears on clean and its pulse exactly 2+DEBOUNCE_CYCLES edges after the first edge that samples the new level. Pulses are combinational-free (registered).
- Latch state, evaluated each cycle from the clean levels:
  - Red only held: q<=1.
  - Blue only held: q<=0.
  - Neither held: q holds.
  - Both held: q holds.
- LED outputs (registered, one cycle after the clean/q update):
  - Both held: led0=1, led1=1 (NAND-equivalent forbidden state).
  - Otherwise: led0=q, led1=~q.
- Simultaneous release of both buttons in one cycle: q keeps its value from before the both-held period, and LEDs return to q/~q.
- Simultaneous press acceptance of both buttons in one cycle: both press pulses fire, LEDs go 1/1, q unchanged.
- Counters saturate by construction: they clear on acceptance and never wrap.

Decomposition:
- Shared package flipflop_pkg:
  - BTN_RELEASED=1'b1, BTN_PRESSED=1'b0.
  - LED0_RST=1'b0, LED1_RST=1'b1.
  - Default DEBOUNCE_CYCLES constant.
- One sub-module, btn_debounce (synchroniser + counter + clean register + press/release pulses). It is instantiated twice; the top holds q and the LED registers.

Test Plan:
- Reset: rst_n=0 with buttons idle -> led0=0, led1=1, clean=1/1, all pulses 0; release reset, hold 20 cycles -> no change.
- Clean red press, DEBOUNCE_CYCLES=4: redbtn 1->0 held 10 cycles -> red_press high exactly one cycle at edge 6 after the change, led0=1/led1=0 one cycle later; release -> red_release pulse, LEDs stay 1/0.
- Bounce rejection, DEBOUNCE_CYCLES=4: redbtn toggles 0,1,0,1 every 2 cycles, then stays 1 -> no pulse, red_clean stays 1, LEDs unchanged.
- Blue after red: red press/release, then blue press -> blue_press pulse, led0=0/led1=1.
- Both held: red held, then blue pressed -> LEDs 1/1; release both on the same cycle -> LEDs return to 1/0 (q=1 kept).
- Reset mid-debounce: redbtn low for 2 accepted-count cycles, assert rst_n=0 -> all reset values immediately; after release with redbtn still low, press accepted a full 2+DEBOUNCE_CYCLES later, not earlier.
